// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: frame/line pattern generator producing gray, const, checkerboard and ramp pixels.
// Defining PATSEQ_SIGNATURE_EN adds a per-frame 16-bit MISR signature (frame_sig, sig_valid).
module pattern_seq_ctrl #(
    parameter int DATA_W    = 12,
    parameter int LINE_LEN  = 1290,
    parameter int NUM_LINES = 1024,
    parameter int CB_LOG2_A = 0,
    parameter int CB_LOG2_B = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_sync,
    input  logic              sync,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [1:0]        x_sel,
    input  logic [DATA_W-1:0] delta_y,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              end_line,
    output logic              end_frame,
    output logic              busy
`ifdef PATSEQ_SIGNATURE_EN
    ,
    output logic [15:0]       frame_sig,
    output logic              sig_valid
`endif
);
    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_LINES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, WAIT} state_t;
    state_t r_state, w_nstate;

    logic [CW-1:0]     r_col, w_ncol;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_row_base, r_const, r_dy;
    logic [2:0]        r_mode;
    logic [1:0]        r_xsel;
    logic              r_pix_valid, r_end_line, r_end_frame, r_busy;
    logic [DATA_W-1:0] r_pix_data, w_pix, w_c, w_step;
    logic              w_last_col, w_last_row, w_frame_start, w_row_adv, w_pa, w_pb;

    assign w_last_col = r_col == COL_LAST;
    assign w_last_row = r_row == ROW_LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nstate;

    // A sync in RUN aborts the line, but the last line always ends the frame.
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE:    w_nstate = (f_sync && sync) ? START : IDLE;
            START:   w_nstate = (r_mode == 3'b000) ? IDLE : RUN;
            RUN:     w_nstate = (w_last_col || sync) ? (w_last_row ? IDLE : (sync ? START : WAIT)) : RUN;
            WAIT:    w_nstate = sync ? START : WAIT;
            default: w_nstate = IDLE;
        endcase
    end

    assign w_frame_start = (r_state == IDLE) && (w_nstate == START);
    assign w_row_adv     = ((r_state == RUN) || (r_state == WAIT)) && (w_nstate == START);
    assign w_ncol        = (r_state == RUN) ? r_col + 1'b1 : '0;

    // Pixel for the column about to be presented, so the output register lines up with RUN.
    assign w_c    = DATA_W'(w_ncol);
    assign w_pa   = 1'((32'(w_ncol) ^ 32'(r_row)) >> CB_LOG2_A);
    assign w_pb   = 1'((32'(w_ncol) ^ 32'(r_row)) >> CB_LOG2_B);
    assign w_step = (r_xsel == 2'b00) ? DATA_W'(0) : (r_xsel == 2'b01) ? DATA_W'(1) :
                    (r_xsel == 2'b10) ? DATA_W'(4) : DATA_W'(8);
    assign w_pix  = (r_mode == 3'b001) ? (w_c ^ (w_c >> 1)) :
                    (r_mode == 3'b010) ? r_const :
                    (r_mode == 3'b011) ? {DATA_W{w_pa}} :
                    (r_mode == 3'b100) ? {DATA_W{~w_pa}} :
                    (r_mode == 3'b101) ? {DATA_W{w_pb}} :
                    (r_mode == 3'b110) ? {DATA_W{~w_pb}} :
                    (r_mode == 3'b111) ? (r_row_base + w_c * w_step) : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_mode      <= '0;
            r_const     <= '0;
            r_xsel      <= '0;
            r_dy        <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_end_line  <= 1'b0;
            r_end_frame <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_mode  <= mode;
                r_const <= const_val;
                r_xsel  <= x_sel;
                r_dy    <= delta_y;
            end
            r_col       <= ((w_nstate == RUN) || (r_state == START)) ? w_ncol : r_col;
            r_row       <= w_frame_start ? '0 : w_row_adv ? r_row + 1'b1 : r_row;
            r_row_base  <= w_frame_start ? '0 : w_row_adv ? r_row_base + r_dy : r_row_base;
            r_pix_valid <= w_nstate == RUN;
            r_pix_data  <= (w_nstate == RUN) ? w_pix : '0;
            r_end_line  <= (w_nstate == RUN) && (w_ncol == COL_LAST);
            r_end_frame <= (w_nstate == RUN) && (w_ncol == COL_LAST) && w_last_row;
            r_busy      <= w_nstate != IDLE;
        end

    assign pix_valid = r_pix_valid;
    assign pix_data  = r_pix_data;
    assign end_line  = r_end_line;
    assign end_frame = r_end_frame;
    assign busy      = r_busy;

`ifdef PATSEQ_SIGNATURE_EN
    logic [15:0] r_sig, r_frame_sig, w_sig_nxt;
    logic        r_sig_valid;

    assign w_sig_nxt = {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10]} ^ 16'(r_pix_data);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sig       <= '0;
            r_frame_sig <= '0;
            r_sig_valid <= 1'b0;
        end else begin
            r_sig       <= w_frame_start ? '0 : r_pix_valid ? w_sig_nxt : r_sig;
            r_sig_valid <= r_end_frame;
            r_frame_sig <= r_end_frame ? w_sig_nxt : r_frame_sig;
        end

    assign frame_sig = r_frame_sig;
    assign sig_valid = r_sig_valid;
`endif
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl: directed checks of pattern_seq_ctrl with LINE_LEN=8, NUM_LINES=3, DATA_W=12.
module tb_pattern_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_sync = 1'b0;
    logic        sync = 1'b0;
    logic [2:0]  mode = '0;
    logic [11:0] const_val = '0;
    logic [1:0]  x_sel = '0;
    logic [11:0] delta_y = '0;
    logic        pix_valid, end_line, end_frame, busy;
    logic [11:0] pix_data;
`ifdef PATSEQ_SIGNATURE_EN
    logic [15:0] frame_sig;
    logic        sig_valid;
`endif
    int n_chk = 0;
    int n_err = 0;

    pattern_seq_ctrl #(.DATA_W(12), .LINE_LEN(8), .NUM_LINES(3), .CB_LOG2_A(0), .CB_LOG2_B(1)) dut (
        .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .mode(mode),
        .const_val(const_val), .x_sel(x_sel), .delta_y(delta_y),
        .pix_valid(pix_valid), .pix_data(pix_data), .end_line(end_line),
        .end_frame(end_frame), .busy(busy)
`ifdef PATSEQ_SIGNATURE_EN
        , .frame_sig(frame_sig), .sig_valid(sig_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input string tag, input logic [2:0] m, input logic [11:0] cv,
                               input logic [1:0] xs, input logic [11:0] dy);
        mode = m; const_val = cv; x_sel = xs; delta_y = dy;
        f_sync = 1'b1; sync = 1'b1;
        @(negedge clk);
        f_sync = 1'b0; sync = 1'b0;
        check({tag, " start busy"}, 32'(busy), 32'(1));
        check({tag, " start vld"}, 32'(pix_valid), 32'(0));
    endtask

    task automatic run_pix(input string tag, input logic [7:0][11:0] e, input int n, input bit last_row);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s p%0d", tag, k), 32'(pix_data), 32'(e[7-k]));
            check($sformatf("%s vld%0d", tag, k), 32'(pix_valid), 32'(1));
            check($sformatf("%s eol%0d", tag, k), 32'(end_line), 32'(k == 7));
            check($sformatf("%s eof%0d", tag, k), 32'(end_frame), 32'(last_row && k == 7));
        end
    endtask

    task automatic gap(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s wait vld%0d", tag, k), 32'(pix_valid), 32'(0));
            check($sformatf("%s wait busy%0d", tag, k), 32'(busy), 32'(1));
        end
    endtask

    task automatic line_sync(input string tag);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check({tag, " lstart vld"}, 32'(pix_valid), 32'(0));
    endtask

    task automatic frame_end(input string tag);
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 32'(0));
        check({tag, " idle vld"}, 32'(pix_valid), 32'(0));
`ifdef PATSEQ_SIGNATURE_EN
        check({tag, " sigv1"}, 32'(sig_valid), 32'(1));
`endif
        @(negedge clk);
`ifdef PATSEQ_SIGNATURE_EN
        check({tag, " sigv0"}, 32'(sig_valid), 32'(0));
`endif
    endtask

    task automatic run_frame(input string tag, input logic [2:0] m, input logic [11:0] cv,
                             input logic [1:0] xs, input logic [11:0] dy,
                             input logic [7:0][11:0] r0, input logic [7:0][11:0] r1,
                             input logic [7:0][11:0] r2);
        start_frame(tag, m, cv, xs, dy);
        run_pix({tag, " r0"}, r0, 8, 1'b0);
        gap(tag, 2);
        line_sync(tag);
        run_pix({tag, " r1"}, r1, 8, 1'b0);
        gap(tag, 1);
        line_sync(tag);
        run_pix({tag, " r2"}, r2, 8, 1'b1);
        frame_end(tag);
    endtask

    localparam logic [7:0][11:0] GRAY = {12'h000, 12'h001, 12'h003, 12'h002, 12'h006, 12'h007, 12'h005, 12'h004};
    localparam logic [7:0][11:0] CBA0 = {12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    localparam logic [7:0][11:0] CBA1 = {12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
    localparam logic [7:0][11:0] CBB0 = {12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    localparam logic [7:0][11:0] CBB2 = {12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF};
    localparam logic [7:0][11:0] RP0  = {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C};
    localparam logic [7:0][11:0] RP1  = {12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'h024, 12'h028, 12'h02C};
    localparam logic [7:0][11:0] RP2  = {12'h020, 12'h024, 12'h028, 12'h02C, 12'h030, 12'h034, 12'h038, 12'h03C};
    localparam logic [7:0][11:0] RW1  = {12'hFFF, 12'h003, 12'h007, 12'h00B, 12'h00F, 12'h013, 12'h017, 12'h01B};
    localparam logic [7:0][11:0] RW2  = {12'hFFE, 12'h002, 12'h006, 12'h00A, 12'h00E, 12'h012, 12'h016, 12'h01A};
    localparam logic [7:0][11:0] AB0  = {12'h000, 12'h008, 12'h010, 12'h018, 12'h020, 12'h028, 12'h030, 12'h038};
    localparam logic [7:0][11:0] AB1  = {12'h003, 12'h00B, 12'h013, 12'h01B, 12'h023, 12'h02B, 12'h033, 12'h03B};
    localparam logic [7:0][11:0] AB2  = {12'h006, 12'h00E, 12'h016, 12'h01E, 12'h026, 12'h02E, 12'h036, 12'h03E};
    localparam logic [7:0][11:0] CST  = {8{12'hA5C}};

    initial begin
        repeat (2) @(negedge clk);
        check("rst vld", 32'(pix_valid), 32'(0));
        check("rst data", 32'(pix_data), 32'(0));
        check("rst eol", 32'(end_line), 32'(0));
        check("rst eof", 32'(end_frame), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        start_frame("pre", 3'b001, 12'h0, 2'b00, 12'h0);
        run_pix("pre", GRAY, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst vld", 32'(pix_valid), 32'(0));
        check("arst data", 32'(pix_data), 32'(0));
        check("arst busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("nofs busy", 32'(busy), 32'(0));
        @(negedge clk);
        check("nofs busy2", 32'(busy), 32'(0));
        check("nofs vld", 32'(pix_valid), 32'(0));

        run_frame("gray", 3'b001, 12'h0, 2'b00, 12'h0, GRAY, GRAY, GRAY);
        run_frame("cbA", 3'b011, 12'h0, 2'b00, 12'h0, CBA0, CBA1, CBA0);
        run_frame("cbB", 3'b110, 12'h0, 2'b00, 12'h0, CBB0, CBB0, CBB2);
        run_frame("ramp", 3'b111, 12'h0, 2'b10, 12'd16, RP0, RP1, RP2);
        run_frame("rwrap", 3'b111, 12'h0, 2'b10, 12'hFFF, RP0, RW1, RW2);
        run_frame("const", 3'b010, 12'hA5C, 2'b00, 12'h0, CST, CST, CST);

        start_frame("abort", 3'b111, 12'h0, 2'b11, 12'd3);
        run_pix("abort r0", AB0, 4, 1'b0);
        sync = 1'b1; mode = 3'b001; x_sel = 2'b00; delta_y = 12'h0;
        @(negedge clk);
        sync = 1'b0;
        check("abort start vld", 32'(pix_valid), 32'(0));
        check("abort start busy", 32'(busy), 32'(1));
        run_pix("abort r1", AB1, 8, 1'b0);
        gap("abort", 1);
        line_sync("abort");
        run_pix("abort r2", AB2, 8, 1'b1);
        frame_end("abort");

        start_frame("none", 3'b000, 12'h0, 2'b00, 12'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("none vld%0d", k), 32'(pix_valid), 32'(0));
            check($sformatf("none busy%0d", k), 32'(busy), 32'(0));
        end

`ifdef PATSEQ_SIGNATURE_EN
        run_frame("sig", 3'b010, 12'h000, 2'b00, 12'h0, {8{12'h000}}, {8{12'h000}}, {8{12'h000}});
        check("sig value", 32'(frame_sig), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
